// File: rtl/mult_sched_pkg.sv
// Shared types and the round-robin pick helper for the multiplier scheduler.
// Types: req_id_t (requester index), tag_t (pipeline tag), pick_t (arbiter result).
// Function: rr_pick(eligible, ptr, num_req) -> {found, index}.
package mult_sched_pkg;

  // The package cannot see a module's NUM_REQ, so IDs are sized for the
  // largest supported configuration (8 requesters); modules slice down.
  localparam int MAX_REQ      = 8;
  localparam int MAX_ID_WIDTH = 3;

  typedef logic [MAX_ID_WIDTH-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  typedef struct packed {
    logic    found;
    req_id_t index;
  } pick_t;

  // First eligible index at or after ptr+1, wrapping modulo num_req.
  // Requires ptr < num_req.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] eligible,
                                    input req_id_t            ptr,
                                    input int                 num_req);
    pick_t p;
    int    idx;
    p = '0;
    for (int off = 1; off <= MAX_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= num_req) idx = idx - num_req;
      if (off <= num_req && !p.found && eligible[idx[2:0]]) begin
        p.found = 1'b1;
        p.index = req_id_t'(idx);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/multiplier_pipelined_multistage.sv
// Unsigned pipelined multiplier: register operands, form two partial products
// (low/high halves of b), then sum. Latency 3 clocks, one result per clock.
// Ports: clk, a_i/b_i operands in, product_o full-width product out. No stall.
module multiplier_pipelined_multistage #(
  parameter  int INPUT_WIDTH  = 8,
  localparam int OUTPUT_WIDTH = 2*INPUT_WIDTH
) (
  input  logic                    clk,
  input  logic [INPUT_WIDTH-1:0]  a_i,
  input  logic [INPUT_WIDTH-1:0]  b_i,
  output logic [OUTPUT_WIDTH-1:0] product_o
);

  localparam int LO_W = INPUT_WIDTH/2;

  logic [INPUT_WIDTH-1:0]  a_q, b_q;
  logic [OUTPUT_WIDTH-1:0] pp_lo_q, pp_hi_q, product_q;

  // Datapath only; validity is tracked by the caller, so no reset here.
  always_ff @(posedge clk) begin
    a_q       <= a_i;
    b_q       <= b_i;
    pp_lo_q   <= OUTPUT_WIDTH'(a_q) * OUTPUT_WIDTH'(b_q[LO_W-1:0]);
    pp_hi_q   <= OUTPUT_WIDTH'(a_q) * OUTPUT_WIDTH'(b_q[INPUT_WIDTH-1:LO_W]);
    product_q <= pp_lo_q + (pp_hi_q << LO_W);
  end

  assign product_o = product_q;

endmodule

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined multiplier among NUM_REQ requesters;
// a tag pipeline alongside the datapath returns each product with its requester ID.
// Ports: clk, rst_n, req_mask/req_valid/req_ready/req_a/req_b (issue side),
// rsp_valid/rsp_id/rsp_product (response side), inflight (outstanding op count).
module mult_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int INPUT_WIDTH  = 8,
  parameter  int LATENCY      = 3,
  localparam int OUTPUT_WIDTH = 2*INPUT_WIDTH,
  localparam int ID_WIDTH     = $clog2(NUM_REQ),
  localparam int INF_W        = $clog2(LATENCY+1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_mask,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_b,
  output logic                           rsp_valid,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [OUTPUT_WIDTH-1:0]        rsp_product,
  output logic [INF_W-1:0]               inflight
);

  pick_t                   pick;
  logic                    grant_vld;
  logic [INPUT_WIDTH-1:0]  mul_a, mul_b;
  logic [OUTPUT_WIDTH-1:0] mul_product;

  req_id_t                 ptr_q, ptr_d;
  tag_t                    tag_q [LATENCY];
  tag_t                    tag_d;
  logic [INF_W-1:0]        inflight_q, inflight_d;
  logic                    unused_id_hi;

  // eligible already includes req_valid, so any grant is a handshake.
  assign pick      = rr_pick(MAX_REQ'(req_valid & req_mask), ptr_q, NUM_REQ);
  assign grant_vld = pick.found & rst_n;

  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && pick.index == req_id_t'(i)) begin
        req_ready[i] = 1'b1;
        mul_a        = req_a[i*INPUT_WIDTH +: INPUT_WIDTH];
        mul_b        = req_b[i*INPUT_WIDTH +: INPUT_WIDTH];
      end
    end
  end

  assign ptr_d       = grant_vld ? pick.index : ptr_q;
  assign tag_d.valid = grant_vld;
  assign tag_d.id    = grant_vld ? pick.index : '0;
  assign inflight_d  = inflight_q + INF_W'(grant_vld) - INF_W'(rsp_valid);

  // Tag pipe always advances in lockstep with the multiplier stages. Reset
  // clears only the tags; whatever the multiplier still holds is masked below.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
      ptr_q      <= req_id_t'(NUM_REQ-1);  // requester 0 searched first
      inflight_q <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
    end
  end

  multiplier_pipelined_multistage #(
    .INPUT_WIDTH (INPUT_WIDTH)
  ) u_mult (
    .clk       (clk),
    .a_i       (mul_a),
    .b_i       (mul_b),
    .product_o (mul_product)
  );

  assign rsp_valid    = tag_q[LATENCY-1].valid;
  assign rsp_id       = rsp_valid ? tag_q[LATENCY-1].id[ID_WIDTH-1:0] : '0;
  assign rsp_product  = rsp_valid ? mul_product : '0;
  assign inflight     = inflight_q;
  assign unused_id_hi = ^tag_q[LATENCY-1].id;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
module tb_mult_rr_scheduler;

  localparam int N = 4;
  localparam int W = 8;
  localparam int L = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_mask = '0, req_valid = '0, req_ready;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [2*W-1:0] rsp_product;
  logic [1:0]     inflight;

  always #5 clk = ~clk;

  mult_rr_scheduler #(.NUM_REQ(N), .INPUT_WIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_mask(req_mask), .req_valid(req_valid),
    .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_product(rsp_product), .inflight(inflight)
  );

  typedef struct { int id; int prod; int due; } exp_t;
  exp_t sb[$];

  int cyc = 0;        // posedges seen so far
  int n_chk = 0;
  int n_fail = 0;
  int mptr = N-1;     // reference: last granted requester
  int last_grant = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
    logic [N*W-1:0] v;
    v = {W'(x3), W'(x2), W'(x1), W'(x0)};
    return v;
  endfunction

  // Monitor: just after each edge, compare the response bus against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    check("inflight", 32'(inflight), 32'(sb.size()));
    check("inflight_max", 32'(inflight <= 2'(L)), 32'd1);
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_product", 32'(rsp_product), 32'(e.prod));
        check("rsp_latency", 32'(cyc), 32'(e.due));
      end
    end else begin
      check("rsp_id_idle", 32'(rsp_id), 32'd0);
      check("rsp_product_idle", 32'(rsp_product), 32'd0);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("rsp_missing", 32'(rsp_valid), 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  // Drive one cycle of inputs, check the grant against the reference
  // arbitration rule and queue the expected response.
  task automatic step(input logic r, input logic [N-1:0] v, input logic [N-1:0] m,
                      input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    logic [N-1:0] el;
    logic [N-1:0] expg;
    int gi;
    @(negedge clk);
    rst_n = r; req_valid = v; req_mask = m; req_a = a; req_b = b;
    #1;
    gi   = -1;
    expg = '0;
    if (!r) begin
      sb.delete();
      mptr = N-1;
    end else begin
      el = v & m;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (mptr + k) % N;
        if (gi < 0 && el[idx]) gi = idx;
      end
    end
    if (gi >= 0) expg[gi] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(expg));
    if (gi >= 0) begin
      sb.push_back('{gi, int'(a[gi*W +: W]) * int'(b[gi*W +: W]), cyc + L});
      mptr = gi;
    end
    last_grant = gi;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, 4'hF, '0, '0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'hF, 4'hF, '0, '0);
  endtask

  initial begin
    do_reset(3);

    // Single issue 5x3 from requester 0.
    step(1'b1, 4'b0001, 4'hF, pack4(5, 0, 0, 0), pack4(3, 0, 0, 0));
    idle(5);

    // Full rotation with all four eligible.
    do_reset(1);
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 4'hF, 4'hF, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40));
      check("rr_rotate", 32'(last_grant), 32'(c % N));
    end
    idle(4);

    // Mask 1010: only requesters 1 and 3, alternating.
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 4'hF, 4'b1010, pack4(7, 8, 9, 10), pack4(11, 12, 13, 14));
      check("masked_never", 32'(req_ready & 4'b0101), 32'd0);
      check("mask_alternate", 32'(last_grant), (c % 2 == 0) ? 32'd1 : 32'd3);
    end
    idle(4);

    // Full-width product then zero product, back to back.
    step(1'b1, 4'b0100, 4'hF, pack4(0, 0, 255, 0), pack4(0, 0, 255, 0));
    step(1'b1, 4'b1000, 4'hF, pack4(0, 0, 0, 0), pack4(0, 0, 0, 100));
    idle(4);

    // Mid-operation reset drops the third in-flight op; arbitration restarts at 0.
    do_reset(1);
    for (int c = 0; c < 3; c++) step(1'b1, 4'hF, 4'hF, pack4(3, 5, 7, 9), pack4(2, 4, 6, 8));
    idle(1);
    do_reset(1);
    step(1'b1, 4'hF, 4'hF, pack4(1, 1, 1, 1), pack4(9, 9, 9, 9));
    check("post_reset_grant", 32'(last_grant), 32'd0);
    idle(4);

    // Randomised traffic.
    for (int c = 0; c < 200; c++) begin
      logic [N-1:0] m;
      m = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'hF;
      step(1'b1, N'($urandom), m, (N*W)'($urandom), (N*W)'($urandom));
    end
    idle(6);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
